// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the cpu_ctrl instruction-sequencing controller.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StWb     = 3'd3,
    StBranch = 3'd4
  } state_e;

  localparam logic [2:0] ClassDpReg  = 3'b000;
  localparam logic [2:0] ClassDpImm  = 3'b001;
  localparam logic [2:0] ClassBranch = 3'b101;

  localparam logic [2:0] ShiftRor = 3'b110;
  localparam logic [3:0] AluAdd   = 4'b0100;

  localparam logic [1:0] PcPlus4  = 2'b00;
  localparam logic [1:0] PcBranch = 2'b01;

  localparam logic [1:0] RsImmShift = 2'b00;
  localparam logic [1:0] RsReg      = 2'b01;
  localparam logic [1:0] RsRotImm   = 2'b10;

  typedef struct packed {
    logic       write_ir;
    logic       write_pc;
    logic       write_reg;
    logic       write_nzcv;
    logic [1:0] pc_s;
    logic       rd_s;
    logic       alu_a_s;
    logic       alu_b_s;
    logic       rm_imm_s;
    logic [1:0] rs_imm_s;
    logic [3:0] alu_op;
    logic [2:0] shift_op;
    logic       illegal;
  } ctrl_t;

  // TST/TEQ/CMP/CMN only update flags.
  function automatic logic is_test_op(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluation; the reserved 1111 encoding never passes.
module cond_check (
  input  logic [3:0] cond,
  input  logic [3:0] NZCV,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = NZCV;

  always_comb begin
    pass = 1'b0;
    case (cond)
      4'b0000: pass = z;
      4'b0001: pass = !z;
      4'b0010: pass = c;
      4'b0011: pass = !c;
      4'b0100: pass = n;
      4'b0101: pass = !n;
      4'b0110: pass = v;
      4'b0111: pass = !v;
      4'b1000: pass = c && !z;
      4'b1001: pass = !c || z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = !z && (n == v);
      4'b1101: pass = z || (n != v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control FSM: FETCH, DECODE, then EXEC/WB for data processing or BRANCH.
module cpu_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IR,
  input  logic [3:0]  NZCV,
  output logic        write_ir,
  output logic        write_pc,
  output logic        write_reg,
  output logic        write_nzcv,
  output logic [1:0]  pc_s,
  output logic        rd_s,
  output logic        ALU_A_s,
  output logic        ALU_B_s,
  output logic        rm_imm_s_ctrl,
  output logic [1:0]  rs_imm_s_ctrl,
  output logic [3:0]  ALU_OP_ctrl,
  output logic [2:0]  Shift_OP_ctrl,
  output logic        illegal,
  output logic [2:0]  state
);

  state_e     state_q, state_d;
  ctrl_t      ctrl, ctrl_out;
  logic       pass;
  logic [2:0] cls;
  logic [3:0] op;
  logic       unused_ir;

  assign cls       = IR[27:25];
  assign op        = IR[24:21];
  assign unused_ir = ^{IR[19:7], IR[3:0]};

  cond_check u_cond_check (
    .cond (IR[31:28]),
    .NZCV (NZCV),
    .pass (pass)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    ctrl    = '0;
    state_d = StFetch;
    case (state_q)
      StFetch: begin
        ctrl.write_ir = 1'b1;
        ctrl.write_pc = 1'b1;
        ctrl.pc_s     = PcPlus4;
        state_d       = StDecode;
      end
      StDecode: begin
        // A failed condition suppresses the instruction entirely, including illegal.
        if (pass) begin
          case (cls)
            ClassDpReg, ClassDpImm: state_d = StExec;
            ClassBranch:            state_d = StBranch;
            default:                ctrl.illegal = 1'b1;
          endcase
        end
      end
      StExec, StWb: begin
        ctrl.alu_op = op;
        if (IR[25]) begin
          ctrl.rm_imm_s = 1'b1;
          ctrl.rs_imm_s = RsRotImm;
          ctrl.shift_op = ShiftRor;
        end else begin
          ctrl.rs_imm_s = IR[4] ? RsReg : RsImmShift;
          ctrl.shift_op = IR[6:4];
        end
        if (state_q == StWb) begin
          ctrl.write_reg  = !is_test_op(op);
          ctrl.write_nzcv = IR[20] || is_test_op(op);
        end else begin
          state_d = StWb;
        end
      end
      StBranch: begin
        ctrl.write_pc = 1'b1;
        ctrl.pc_s     = PcBranch;
        if (IR[24]) begin
          ctrl.write_reg = 1'b1;
          ctrl.rd_s      = 1'b1;
          ctrl.alu_a_s   = 1'b1;
          ctrl.alu_b_s   = 1'b1;
          ctrl.alu_op    = AluAdd;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // Reset must silence strobes even though the held state is FETCH.
  assign ctrl_out = rst ? ctrl : '0;

  assign write_ir      = ctrl_out.write_ir;
  assign write_pc      = ctrl_out.write_pc;
  assign write_reg     = ctrl_out.write_reg;
  assign write_nzcv    = ctrl_out.write_nzcv;
  assign pc_s          = ctrl_out.pc_s;
  assign rd_s          = ctrl_out.rd_s;
  assign ALU_A_s       = ctrl_out.alu_a_s;
  assign ALU_B_s       = ctrl_out.alu_b_s;
  assign rm_imm_s_ctrl = ctrl_out.rm_imm_s;
  assign rs_imm_s_ctrl = ctrl_out.rs_imm_s;
  assign ALU_OP_ctrl   = ctrl_out.alu_op;
  assign Shift_OP_ctrl = ctrl_out.shift_op;
  assign illegal       = ctrl_out.illegal;
  assign state         = state_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: per-instruction expected cycle plans plus directed literal checks.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IR;
  logic [3:0]  NZCV;
  logic        write_ir, write_pc, write_reg, write_nzcv;
  logic [1:0]  pc_s;
  logic        rd_s, ALU_A_s, ALU_B_s, rm_imm_s_ctrl;
  logic [1:0]  rs_imm_s_ctrl;
  logic [3:0]  ALU_OP_ctrl;
  logic [2:0]  Shift_OP_ctrl;
  logic        illegal;
  logic [2:0]  state;

  cpu_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .IR            (IR),
    .NZCV          (NZCV),
    .write_ir      (write_ir),
    .write_pc      (write_pc),
    .write_reg     (write_reg),
    .write_nzcv    (write_nzcv),
    .pc_s          (pc_s),
    .rd_s          (rd_s),
    .ALU_A_s       (ALU_A_s),
    .ALU_B_s       (ALU_B_s),
    .rm_imm_s_ctrl (rm_imm_s_ctrl),
    .rs_imm_s_ctrl (rs_imm_s_ctrl),
    .ALU_OP_ctrl   (ALU_OP_ctrl),
    .Shift_OP_ctrl (Shift_OP_ctrl),
    .illegal       (illegal),
    .state         (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       wir, wpc, wreg, wnzcv;
    logic [1:0] pcs;
    logic       rds, alua, alub, rmimm;
    logic [1:0] rsimm;
    logic [3:0] aluop;
    logic [2:0] shop;
    logic       ill;
  } vec_t;

  vec_t act;
  assign act = {state, write_ir, write_pc, write_reg, write_nzcv, pc_s, rd_s, ALU_A_s,
                ALU_B_s, rm_imm_s_ctrl, rs_imm_s_ctrl, ALU_OP_ctrl, Shift_OP_ctrl, illegal};

  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Conditions come in complementary pairs; bit 0 inverts the base test.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return (c == 4'hF) ? 1'b0 : (base ^ c[0]);
  endfunction

  // Queue one expected output vector per cycle of the instruction, starting at FETCH.
  task automatic plan(input logic [31:0] ir, input logic [3:0] f, output int n);
    vec_t v;
    int   cls;
    bit   ok, dp, br, flag_only;
    cls = int'(ir[27:25]);
    ok  = cond_ok(ir[31:28], f);
    dp  = (cls == 0) || (cls == 1);
    br  = (cls == 5);
    v = '0; v.wir = 1; v.wpc = 1;
    exp_q.push_back(v);
    v = '0; v.st = 3'd1; v.ill = ok && !(dp || br);
    exp_q.push_back(v);
    n = 2;
    if (!ok || !(dp || br)) return;
    if (br) begin
      v = '0; v.st = 3'd4; v.wpc = 1; v.pcs = 2'd1;
      if (ir[24]) begin
        v.wreg = 1; v.rds = 1; v.alua = 1; v.alub = 1; v.aluop = 4'd4;
      end
      exp_q.push_back(v);
      n = 3;
      return;
    end
    v = '0; v.st = 3'd2; v.aluop = ir[24:21];
    if (cls == 1) begin
      v.rmimm = 1; v.rsimm = 2'd2; v.shop = 3'd6;
    end else begin
      v.rsimm = ir[4] ? 2'd1 : 2'd0;
      v.shop  = ir[6:4];
    end
    exp_q.push_back(v);
    flag_only = (ir[24:21] >= 4'd8) && (ir[24:21] <= 4'd11);
    v.st = 3'd3; v.wreg = !flag_only; v.wnzcv = ir[20] || flag_only;
    exp_q.push_back(v);
    n = 4;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL cycle_compare t=%0t: actual %h required %h", $time, act, e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, a, e);
    end
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [31:0] ir, input logic [3:0] f, output int n);
    IR   = ir;
    NZCV = f;
    plan(ir, f, n);
  endtask

  logic [31:0] dir_ir[7] = '{32'hE0810312, 32'hE0810142, 32'hE0810372, 32'hE1000002,
                             32'hE0E10002, 32'hE1810002, 32'hF0810002};

  initial begin
    int n;
    rst  = 1'b1;
    IR   = 32'h0;
    NZCV = 4'h0;
    #1 rst = 1'b0;
    #2;
    chk("reset_state", 32'(state), 0);
    chk("reset_write_ir", 32'(write_ir), 0);
    chk("reset_write_pc", 32'(write_pc), 0);
    repeat (2) nxt();
    chk("reset_held_state", 32'(state), 0);
    rst = 1'b1;
    #1;
    chk("release_write_ir", 32'(write_ir), 1);

    // ADD R0,R1,R2
    run(32'hE0810002, 4'h0, n);
    nxt();
    mid(); chk("add_decode_wreg", 32'(write_reg), 0); nxt();
    mid(); chk("add_exec_state", 32'(state), 2); chk("add_exec_wreg", 32'(write_reg), 0);
    chk("add_exec_aluop", 32'(ALU_OP_ctrl), 4); nxt();
    mid(); chk("add_wb_wreg", 32'(write_reg), 1); chk("add_wb_nzcv", 32'(write_nzcv), 0);
    chk("add_wb_aluop", 32'(ALU_OP_ctrl), 4); nxt();

    // CMP R1,#5
    run(32'hE3510005, 4'h0, n);
    nxt(); nxt();
    mid(); chk("cmp_rm_imm", 32'(rm_imm_s_ctrl), 1); chk("cmp_rs_imm", 32'(rs_imm_s_ctrl), 2);
    nxt();
    mid(); chk("cmp_wb_wreg", 32'(write_reg), 0); chk("cmp_wb_nzcv", 32'(write_nzcv), 1);
    nxt();

    // BEQ not taken, then taken
    run(32'h0A000003, 4'b0000, n);
    nxt();
    mid(); chk("beq_fail_wpc", 32'(write_pc), 0); chk("beq_fail_state", 32'(state), 1); nxt();
    chk("beq_fail_back", 32'(state), 0);
    run(32'h0A000003, 4'b0100, n);
    nxt(); nxt();
    mid(); chk("beq_state", 32'(state), 4); chk("beq_pc_s", 32'(pc_s), 1);
    chk("beq_wpc", 32'(write_pc), 1); chk("beq_wreg", 32'(write_reg), 0); nxt();

    // BL
    run(32'hEB000010, 4'h0, n);
    nxt(); nxt();
    mid(); chk("bl_wpc", 32'(write_pc), 1); chk("bl_wreg", 32'(write_reg), 1);
    chk("bl_rd_s", 32'(rd_s), 1); chk("bl_alu_a", 32'(ALU_A_s), 1);
    chk("bl_alu_b", 32'(ALU_B_s), 1); nxt();

    // Undecodable class 110
    run(32'hEC000000, 4'h0, n);
    nxt();
    mid(); chk("ill_pulse", 32'(illegal), 1); chk("ill_wreg", 32'(write_reg), 0); nxt();
    chk("ill_back_state", 32'(state), 0); chk("ill_cleared", 32'(illegal), 0);

    foreach (dir_ir[i]) begin
      run(dir_ir[i], 4'h0, n);
      repeat (n) nxt();
    end
    for (int c = 0; c < 16; c++) begin
      for (int k = 0; k < 2; k++) begin
        run({4'(c), 28'h0810002}, (k == 0) ? 4'b0100 : 4'b1001, n);
        repeat (n) nxt();
      end
    end

    // Reset mid-EXEC aborts the instruction
    run(32'hE0810002, 4'h0, n);
    nxt(); nxt();
    mid();
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_mid_state", 32'(state), 0); chk("rst_mid_wreg", 32'(write_reg), 0);
    chk("rst_mid_wir", 32'(write_ir), 0);
    nxt();
    chk("rst_hold_state", 32'(state), 0); chk("rst_hold_wreg", 32'(write_reg), 0);
    rst = 1'b1;
    #1;
    chk("rst_rel_wir", 32'(write_ir), 1); chk("rst_rel_wpc", 32'(write_pc), 1);
    run(32'hE0810002, 4'h0, n);
    repeat (n) nxt();
    mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
